// File: rtl/wb_initiator_pkg.sv
// Shared types and width constants for the Wishbone single-transaction initiator.
package wb_initiator_pkg;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Command captured at acceptance and replayed on the bus for the whole cycle.
    typedef struct packed {
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
    } req_t;

endpackage

// File: rtl/wb_initiator_if.sv
// Command/response handshake plus Wishbone master request/response signals.
interface wb_initiator_if;
    import wb_initiator_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [ADR_W-1:0] cmd_adr;
    logic [DAT_W-1:0] cmd_dat;
    logic [SEL_W-1:0] cmd_sel;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [DAT_W-1:0] rsp_dat;
    logic             rsp_err;

    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [SEL_W-1:0] wbm_sel_o;
    logic [ADR_W-1:0] wbm_adr_o;
    logic [DAT_W-1:0] wbm_dat_o;
    logic             wbm_ack_i;
    logic [DAT_W-1:0] wbm_dat_i;

    // Initiator side: accepts commands, returns responses, masters the bus.
    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
               wbm_ack_i, wbm_dat_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    // Environment side: command producer, response consumer and bus slave.
    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
               wbm_ack_i, wbm_dat_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

endinterface

// File: rtl/wb_initiator_timer.sv
// Bus-cycle watchdog: cleared on bus entry, counts unacknowledged bus clocks.
module wb_initiator_timer
    import wb_initiator_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q;

    // Cycle counter; holds when not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Fires on the edge where the count would reach LIMIT.
    assign expired_c = enable && (count_q == LAST);

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone initiator: command in, one bus cycle, response out.
// Optional bus-cycle timeout enabled by defining WB_INITIATOR_TIMEOUT_EN.
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int unsigned      TIMEOUT_CYCLES = 255,
    parameter logic [DAT_W-1:0] IDLE_RDATA     = 32'h0
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_ni,
    wb_initiator_if.master bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_initiator: TIMEOUT_CYCLES out of range 1..65535");
    end

    state_e           state_q, state_d;
    req_t             req_q, req_d;
    logic             cyc_q, cyc_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;

`ifdef WB_INITIATOR_TIMEOUT_EN
    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expired_c;

    wb_initiator_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .clear     (tmr_clear),
        .enable    (tmr_enable),
        .expired_c (tmr_expired_c)
    );
`endif

    // State and all output registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cyc_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= IDLE_RDATA;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cyc_q       <= cyc_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cyc_d       = cyc_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
`ifdef WB_INITIATOR_TIMEOUT_EN
        tmr_clear   = 1'b0;
        tmr_enable  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                cyc_d       = 1'b0;
                if (bus.cmd_valid && cmd_ready_q) begin
                    req_d.we    = bus.cmd_we;
                    req_d.adr   = bus.cmd_adr;
                    req_d.dat   = bus.cmd_dat;
                    req_d.sel   = bus.cmd_sel;
                    cyc_d       = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = BUS;
`ifdef WB_INITIATOR_TIMEOUT_EN
                    tmr_clear   = 1'b1;
`endif
                end
            end
            BUS: begin
                cmd_ready_d = 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
                tmr_enable  = !bus.wbm_ack_i;
`endif
                // Ack takes priority over a timeout on the same edge.
                if (bus.wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = req_q.we ? IDLE_RDATA : bus.wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
`ifdef WB_INITIATOR_TIMEOUT_EN
                end else if (tmr_expired_c) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = IDLE_RDATA;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
`endif
                end
            end
            RESP: begin
                cmd_ready_d = 1'b0;
                cyc_d       = 1'b0;
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_dat_d   = IDLE_RDATA;
                    rsp_err_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                cmd_ready_d = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = req_q.we;
    assign bus.wbm_adr_o = req_q.adr;
    assign bus.wbm_dat_o = req_q.dat;
    assign bus.wbm_sel_o = req_q.sel;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator against a registered-ack project-select slave.
module tb_wb_initiator;
    import wb_initiator_pkg::*;

    localparam logic [31:0] IDLE = 32'hDEAD_BEEF;
    localparam int unsigned TMO  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    wb_initiator_if bus ();

    wb_initiator #(
        .TIMEOUT_CYCLES (TMO),
        .IDLE_RDATA     (IDLE)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    // Project-select slave: ack is registered and stays high while cyc is high.
    logic [31:0] active_project;
    logic [31:0] oeb_lo;
    logic [31:0] oeb_hi;
    logic        hit;

    always_comb begin
        hit = 1'b0;
        if (bus.wbm_adr_o == 32'h3000_0000 || bus.wbm_adr_o == 32'h3000_0004 ||
            bus.wbm_adr_o == 32'h3000_0008)
            hit = 1'b1;
        if (bus.wbm_we_o && bus.wbm_adr_o >= 32'h3000_0400 && bus.wbm_adr_o <= 32'h3000_0417)
            hit = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wbm_ack_i  <= 1'b0;
            bus.wbm_dat_i  <= 32'h0;
            active_project <= 32'h0;
            oeb_lo         <= 32'h0;
            oeb_hi         <= 32'h0;
        end else begin
            bus.wbm_ack_i <= bus.wbm_cyc_o && bus.wbm_stb_o && hit;
            case (bus.wbm_adr_o)
                32'h3000_0000: bus.wbm_dat_i <= active_project;
                32'h3000_0004: bus.wbm_dat_i <= oeb_lo;
                32'h3000_0008: bus.wbm_dat_i <= oeb_hi;
                default:       bus.wbm_dat_i <= 32'h0;
            endcase
            if (bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.wbm_sel_o[b]) begin
                        case (bus.wbm_adr_o)
                            32'h3000_0000: active_project[8*b +: 8] <= bus.wbm_dat_o[8*b +: 8];
                            32'h3000_0004: oeb_lo[8*b +: 8]         <= bus.wbm_dat_o[8*b +: 8];
                            32'h3000_0008: oeb_hi[8*b +: 8]         <= bus.wbm_dat_o[8*b +: 8];
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Count bus cycles started (rising cyc).
    int   cyc_rises = 0;
    logic cyc_prev  = 1'b0;
    always @(posedge clk) begin
        cyc_prev <= bus.wbm_cyc_o;
        if (bus.wbm_cyc_o && !cyc_prev) cyc_rises <= cyc_rises + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 32'h0;
        bus.cmd_dat   = 32'h0;
        bus.cmd_sel   = 4'h0;
        bus.rsp_ready = 1'b0;

        // Held in reset
        repeat (3) tick();
        check("rst_cyc",       32'(bus.wbm_cyc_o), 0);
        check("rst_stb",       32'(bus.wbm_stb_o), 0);
        check("rst_we",        32'(bus.wbm_we_o),  0);
        check("rst_sel",       32'(bus.wbm_sel_o), 0);
        check("rst_adr",       bus.wbm_adr_o,      0);
        check("rst_dat",       bus.wbm_dat_o,      0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_err",   32'(bus.rsp_err),   0);
        check("rst_rsp_dat",   bus.rsp_dat,        IDLE);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 0);

        rst_n = 1'b1;
        tick();
        check("rel_cmd_ready", 32'(bus.cmd_ready), 1);

        // Write 3 to active project
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b1;
        bus.cmd_adr   = 32'h3000_0000;
        bus.cmd_dat   = 32'h0000_0003;
        bus.cmd_sel   = 4'hF;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_adr   = 32'h0;
        bus.cmd_dat   = 32'h0BAD_0BAD;
        check("wr_cyc_n0",   32'(bus.wbm_cyc_o), 1);
        check("wr_stb_n0",   32'(bus.wbm_stb_o), 1);
        check("wr_we",       32'(bus.wbm_we_o),  1);
        check("wr_adr",      bus.wbm_adr_o,      32'h3000_0000);
        check("wr_dat",      bus.wbm_dat_o,      32'h0000_0003);
        check("wr_sel",      32'(bus.wbm_sel_o), 32'hF);
        check("wr_cmd_rdy",  32'(bus.cmd_ready), 0);
        check("wr_rsp_n0",   32'(bus.rsp_valid), 0);
        tick();
        check("wr_cyc_n1",   32'(bus.wbm_cyc_o), 1);
        check("wr_adr_n1",   bus.wbm_adr_o,      32'h3000_0000);
        check("wr_dat_n1",   bus.wbm_dat_o,      32'h0000_0003);
        check("wr_rsp_n1",   32'(bus.rsp_valid), 0);
        tick();
        check("wr_cyc_n2",   32'(bus.wbm_cyc_o), 0);
        check("wr_stb_n2",   32'(bus.wbm_stb_o), 0);
        check("wr_rsp_n2",   32'(bus.rsp_valid), 1);
        check("wr_err",      32'(bus.rsp_err),   0);
        check("wr_rsp_dat",  bus.rsp_dat,        IDLE);
        check("wr_slave",    active_project,     32'h0000_0003);

        // Stall the response for 5 cycles while a read is already offered
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 32'h3000_0000;
        bus.cmd_dat   = 32'h0;
        bus.cmd_sel   = 4'h5;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 32'(bus.rsp_valid), 1);
            check("stall_dat",   bus.rsp_dat,        IDLE);
            check("stall_err",   32'(bus.rsp_err),   0);
            check("stall_ready", 32'(bus.cmd_ready), 0);
            check("stall_cyc",   32'(bus.wbm_cyc_o), 0);
        end
        check("stall_txns", 32'(cyc_rises), 1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("pop_valid",  32'(bus.rsp_valid), 0);
        check("pop_ready",  32'(bus.cmd_ready), 1);

        // Read back active project with a partial byte-lane mask
        tick();
        bus.cmd_valid = 1'b0;
        check("rd_cyc",  32'(bus.wbm_cyc_o), 1);
        check("rd_we",   32'(bus.wbm_we_o),  0);
        check("rd_sel",  32'(bus.wbm_sel_o), 32'h5);
        check("rd_adr",  bus.wbm_adr_o,      32'h3000_0000);
        tick();
        check("rd_cyc_n1", 32'(bus.wbm_cyc_o), 1);
        tick();
        check("rd_cyc_n2", 32'(bus.wbm_cyc_o), 0);
        check("rd_valid",  32'(bus.rsp_valid), 1);
        check("rd_dat",    bus.rsp_dat,        32'h0000_0003);
        check("rd_err",    32'(bus.rsp_err),   0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        check("rd_txns",     32'(cyc_rises),     2);
        check("rd_no_rsp",   32'(bus.rsp_valid), 0);

        // Write with no byte lanes selected is still issued
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b1;
        bus.cmd_adr   = 32'h3000_0404;
        bus.cmd_dat   = 32'h1234_5678;
        bus.cmd_sel   = 4'h0;
        tick();
        bus.cmd_valid = 1'b0;
        check("sel0_cyc", 32'(bus.wbm_cyc_o), 1);
        check("sel0_we",  32'(bus.wbm_we_o),  1);
        check("sel0_sel", 32'(bus.wbm_sel_o), 0);
        check("sel0_adr", bus.wbm_adr_o,      32'h3000_0404);
        check("sel0_dat", bus.wbm_dat_o,      32'h1234_5678);
        tick();
        tick();
        check("sel0_valid", 32'(bus.rsp_valid), 1);
        check("sel0_err",   32'(bus.rsp_err),   0);
        check("sel0_rdat",  bus.rsp_dat,        IDLE);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Read an unmapped address: nothing acks
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 32'h3000_0FF0;
        bus.cmd_sel   = 4'hF;
        tick();
        bus.cmd_valid = 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 100 && !bus.rsp_valid; i++) begin
            if (bus.wbm_cyc_o) n++;
            tick();
        end
        check("tmo_valid", 32'(bus.rsp_valid), 1);
        check("tmo_cycles", 32'(n),            TMO);
        check("tmo_cyc",   32'(bus.wbm_cyc_o), 0);
        check("tmo_err",   32'(bus.rsp_err),   1);
        check("tmo_dat",   bus.rsp_dat,        IDLE);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("tmo_pop_err", 32'(bus.rsp_err), 0);
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
`else
        repeat (1000) tick();
        check("hang_cyc",   32'(bus.wbm_cyc_o), 1);
        check("hang_valid", 32'(bus.rsp_valid), 0);
        check("hang_err",   32'(bus.rsp_err),   0);
`endif

        // Reset pulse in the middle of a bus cycle
        check("pre_rst_cyc", 32'(bus.wbm_cyc_o), 1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_cyc",   32'(bus.wbm_cyc_o), 0);
        check("mid_rst_stb",   32'(bus.wbm_stb_o), 0);
        check("mid_rst_valid", 32'(bus.rsp_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(bus.cmd_ready), 1);
        n = 0;
        repeat (20) begin
            tick();
            if (bus.rsp_valid || bus.wbm_cyc_o) n++;
        end
        check("post_rst_quiet", 32'(n), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
